// File: rtl/clk_div_prog.sv
// Programmable multi-channel clock divider with per-channel shadow configuration.
// New divisors are applied only on a wrap edge, so no output period is ever cut short.
module clk_div_prog #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned DEFAULT_DIV = 5000000,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0]  div_q  [NUM_CH];
    logic [WIDTH-1:0]  div_d  [NUM_CH];
    logic [WIDTH-1:0]  sdiv_q [NUM_CH];
    logic [WIDTH-1:0]  sdiv_d [NUM_CH];
    logic [WIDTH-1:0]  cnt_q  [NUM_CH];
    logic [WIDTH-1:0]  cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] smode_q, smode_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] acc, wrap, apply;

    // Out-of-range channels never match, so they read ready and are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i) && pend_q[i]) begin
                cfg_ready = 1'b0;
            end
        end
    end

    always_comb begin
        div_d     = div_q;
        sdiv_d    = sdiv_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        smode_d   = smode_q;
        pend_d    = pend_q;
        clk_out_d = clk_out_q;
        tick_d    = '0;
        acc       = '0;
        wrap      = '0;
        apply     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc[i] = cfg_valid && (cfg_ch == CH_W'(i)) && !pend_q[i];
            if (sync_restart) begin
                if (acc[i]) begin
                    div_d[i]  = cfg_div;
                    mode_d[i] = cfg_mode;
                end else if (pend_q[i]) begin
                    div_d[i]  = sdiv_q[i];
                    mode_d[i] = smode_q[i];
                end
                pend_d[i]    = 1'b0;
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                tick_d[i]    = 1'b0;
            end else begin
                // >= rather than == so a counter left above a reduced divisor still wraps
                wrap[i]  = enable[i] && (div_q[i] != '0) && (cnt_q[i] >= div_q[i] - WIDTH'(1));
                apply[i] = pend_q[i] && (wrap[i] || (div_q[i] == '0) || !enable[i]);
                tick_d[i] = wrap[i];
                if (div_q[i] == '0) begin
                    cnt_d[i]     = '0;
                    clk_out_d[i] = 1'b0;
                end else if (enable[i]) begin
                    cnt_d[i]     = wrap[i] ? '0 : cnt_q[i] + WIDTH'(1);
                    clk_out_d[i] = mode_q[i] ? wrap[i] : (clk_out_q[i] ^ wrap[i]);
                end else begin
                    clk_out_d[i] = clk_out_q[i] & ~mode_q[i];
                end
                if (apply[i]) begin
                    div_d[i]  = sdiv_q[i];
                    mode_d[i] = smode_q[i];
                    pend_d[i] = 1'b0;
                    cnt_d[i]  = '0;
                    if (sdiv_q[i] == '0) begin
                        clk_out_d[i] = 1'b0;
                        tick_d[i]    = 1'b0;
                    end else if (smode_q[i]) begin
                        clk_out_d[i] = tick_d[i];
                    end else if (mode_q[i]) begin
                        clk_out_d[i] = 1'b0;
                    end
                end
                if (acc[i]) begin
                    sdiv_d[i]  = cfg_div;
                    smode_d[i] = cfg_mode;
                    pend_d[i]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]  <= DefDiv;
                sdiv_q[i] <= DefDiv;
                cnt_q[i]  <= '0;
            end
            mode_q    <= '0;
            smode_q   <= '0;
            pend_q    <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            div_q     <= div_d;
            sdiv_q    <= sdiv_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            smode_q   <= smode_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_CH, 4, number of independent divider channels (1..16)
- WIDTH, 24, divisor and counter width in bits
- DEFAULT_DIV, 5000000, divisor loaded into every channel at reset
REQ-002 CH_W SHALL be a derived local value: max(1, ceil(log2(NUM_CH))).
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_in, input, 1, sole clock; all logic on rising edge
- reset, input, 1, asynchronous active-high reset
- enable, input, NUM_CH, per-channel run enable
- sync_restart, input, 1, synchronous phase realign of all channels
- cfg_valid, input, 1, configuration request
- cfg_ready, output, 1, configuration accept-ready for channel cfg_ch
- cfg_ch, input, CH_W, target channel of request
- cfg_div, input, WIDTH, new divisor
- cfg_mode, input, 1, 0 = toggle (square wave), 1 = pulse
- clk_out, output, NUM_CH, divided clock per channel
- tick, output, NUM_CH, one-cycle strobe at each counter wrap

Function
REQ-004 Each channel SHALL hold an active divisor, active mode, a WIDTH-bit counter, a shadow divisor/mode, and a pending flag.
REQ-005 On an edge with enable[i]=1 and active divisor D>=1, counter[i] SHALL increment; when counter[i]==D-1 it SHALL wrap to 0 on that edge (a wrap edge).
REQ-006 tick[i] SHALL be registered and high for exactly the cycle following each wrap edge, low otherwise.
REQ-007 Toggle mode: clk_out[i] SHALL invert on each wrap edge, giving a period of 2*D clk_in cycles and 50% duty.
REQ-008 Pulse mode: clk_out[i] SHALL equal tick[i].
REQ-009 D=1 SHALL wrap on every enabled edge (tick held high; toggle output at clk_in/2).
REQ-010 D=0 SHALL disable the channel: counter, clk_out, and tick held at 0.
REQ-011 enable[i]=0 SHALL freeze counter[i] and clk_out[i]; tick[i] SHALL be 0 on the following cycle.
REQ-012 cfg_ready SHALL be high when the pending flag of channel cfg_ch is clear; cfg_ch values >= NUM_CH SHALL read cfg_ready=1, and requests to them SHALL be discarded.
REQ-013 A request SHALL be accepted on an edge where cfg_valid and cfg_ready are both 1; cfg_div/cfg_mode go to the shadow registers and the pending flag is set.
REQ-014 A pending configuration SHALL take effect on the channel's next wrap edge: the counter restarts at 0 with the new D, and no partial period is produced (glitch-free).
REQ-015 A pending configuration SHALL take effect on the next edge if the channel is disabled (D=0) or enable[i]=0.
REQ-016 When a pending configuration takes effect, the pending flag SHALL clear on that same edge, so cfg_ready is high the next cycle.
REQ-017 A mode change to toggle SHALL restart clk_out[i] at 0.
REQ-018 sync_restart=1 SHALL do the following on that edge for all channels: apply pending configurations, counters:=0, clk_out:=0, tick:=0, regardless of enable.
REQ-019 A configuration accepted on the same edge as sync_restart SHALL take effect immediately on that edge.
REQ-020 sync_restart SHALL have priority over a wrap edge on the same edge; the wrap SHALL produce no tick.
REQ-021 Counter arithmetic SHALL be unsigned modulo D; the counter SHALL never exceed D-1 except as stated in REQ-022.
REQ-022 If a counter exceeds D-1 after D is reduced, the next enabled edge SHALL wrap it to 0.

Reset
REQ-023 While reset is high, asynchronously:
- counters=0, clk_out=0, tick=0
- pending flags clear, active and shadow divisor=DEFAULT_DIV, mode=toggle
- cfg_ready=1
REQ-024 After reset deasserts, the first wrap SHALL occur on the D-th enabled edge.
REQ-025 Reset asserted mid-period or with a configuration pending SHALL discard all pending state.

Verification (NUM_CH=2, WIDTH=8, DEFAULT_DIV=4)
REQ-026 Reset release, enable=11 -> tick pulses on cycles 4, 8, 12; clk_out[0] is high for 4 cycles and low for 4 cycles.
REQ-027 cfg ch0 div=3 issued mid-period -> cfg_ready low until the next wrap, old period completes, then tick every 3 cycles with no short pulse.
REQ-028 cfg ch1 div=1 mode=pulse, then div=0 -> tick[1]/clk_out[1] constant high, then held 0 after the next edge.
REQ-029 enable[0] dropped for 5 cycles mid-count -> clk_out[0] frozen and tick[0]=0; on re-enable the count resumes from the frozen value.
REQ-030 sync_restart together with cfg ch0 div=6 -> both channels at counter 0 and clk_out 0; ch0 ticks 6 cycles later and ch1 ticks 4 cycles later.
REQ-031 Reset asserted while ch0 update pending -> outputs 0 immediately, cfg_ready=1, and D=4 resumes after release.
